// File: rtl/sig_mult_seq_if.sv
// Operand/result handshake bundle for the iterative significand multiplier.
// master drives operands and result acceptance; slave is the multiplier.
interface sig_mult_seq_if #(
  parameter int unsigned sig_width = 23
);
  localparam int unsigned W = sig_width + 1;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic         norm_inc;
  logic         guard_bit;
  logic         round_bit;
  logic         sticky_bit;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, norm_inc, guard_bit, round_bit, sticky_bit
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, norm_inc, guard_bit, round_bit, sticky_bit
  );
endinterface

// File: rtl/sig_mult_seq.sv
// Iterative radix-4 Booth significand multiplier: one digit per cycle into a
// carry-save accumulator, one carry-propagate add, then normalize + G/R/S.
module sig_mult_seq #(
  parameter int unsigned sig_width = 23
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  sig_mult_seq_if.slave bus
);
  localparam int unsigned W  = sig_width + 1;
  localparam int unsigned N  = (sig_width + 3) / 2;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned BW = 2 * N + 1;
  localparam int unsigned MW = W + 2;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_RESOLVE, S_HOLD} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W-1:0]    mcand_q;
  logic [BW-1:0]   mplier_q;
  logic [PW-1:0]   sum_q;
  logic [PW-1:0]   carry_q;
  logic [N-1:0]    neg_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    product_q;
  logic            norm_inc_q;
  logic            guard_q;
  logic            round_q;
  logic            sticky_q;

  logic [2:0]      trip;
  logic            neg_c;
  logic            two_c;
  logic            zero_c;
  logic [MW-1:0]   mag;
  logic [MW-1:0]   ppf;
  logic [PW-1:0]   pp_sh;
  logic [PW-1:0]   sum_n;
  logic [PW-1:0]   carry_n;
  logic [PW-1:0]   neg_full;
  logic [PW-1:0]   prod_full;
  logic [W-1:0]    res_prod;
  logic            res_g;
  logic            res_r;
  logic            res_s;

  // Multiplier register shifts right by two per digit, so the current triplet is always at [2:0].
  assign trip = mplier_q[2:0];

  // Radix-4 Booth recode into sign / x2 / zero controls.
  always_comb begin
    neg_c  = 1'b0;
    two_c  = 1'b0;
    zero_c = 1'b0;
    case (trip)
      3'b000, 3'b111: zero_c = 1'b1;
      3'b001, 3'b010: zero_c = 1'b0;
      3'b011:         two_c  = 1'b1;
      3'b100: begin
        neg_c = 1'b1;
        two_c = 1'b1;
      end
      3'b101, 3'b110: neg_c  = 1'b1;
      default:        zero_c = 1'b1;
    endcase
  end

  // Ones-complement partial product; the +1 for negative digits is kept in neg_q
  // and folded into the final add at weight 4^k.
  assign mag   = zero_c ? '0 : (two_c ? {1'b0, mcand_q, 1'b0} : {2'b00, mcand_q});
  assign ppf   = neg_c ? ~mag : mag;
  assign pp_sh = {{(PW - MW){ppf[MW-1]}}, ppf} << {cnt_q, 1'b0};

  // 3:2 compressor; all arithmetic is modulo 2^PW, which is exact because P < 2^PW.
  assign sum_n   = sum_q ^ carry_q ^ pp_sh;
  assign carry_n = {(sum_q[PW-2:0] & carry_q[PW-2:0]) |
                    (sum_q[PW-2:0] & pp_sh[PW-2:0])   |
                    (carry_q[PW-2:0] & pp_sh[PW-2:0]), 1'b0};

  always_comb begin
    neg_full = '0;
    for (int k = 0; k < int'(N); k++) begin
      neg_full[2*k] = neg_q[k];
    end
  end

  assign prod_full = sum_q + carry_q + neg_full;

  // Normalize to a hidden-bit MSB and pick guard/round/sticky below it.
  always_comb begin
    if (prod_full[PW-1]) begin
      res_prod = prod_full[PW-1:W];
      res_g    = prod_full[W-1];
      res_r    = prod_full[W-2];
      res_s    = |prod_full[W-3:0];
    end else begin
      res_prod = prod_full[PW-2:W-1];
      res_g    = prod_full[W-2];
      res_r    = prod_full[W-3];
      res_s    = |prod_full[W-4:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      neg_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      norm_inc_q  <= 1'b0;
      guard_q     <= 1'b0;
      round_q     <= 1'b0;
      sticky_q    <= 1'b0;
    end else if (enable) begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            mcand_q    <= bus.a;
            mplier_q   <= BW'({bus.b, 1'b0});
            sum_q      <= '0;
            carry_q    <= '0;
            neg_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_ITER;
          end
        end
        S_ITER: begin
          sum_q    <= sum_n;
          carry_q  <= carry_n;
          neg_q    <= {neg_c, neg_q[N-1:1]};
          mplier_q <= mplier_q >> 2;
          if (cnt_q == CW'(N - 1)) begin
            state_q <= S_RESOLVE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESOLVE: begin
          product_q   <= res_prod;
          norm_inc_q  <= prod_full[PW-1];
          guard_q     <= res_g;
          round_q     <= res_r;
          sticky_q    <= res_s;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.product    = product_q;
  assign bus.norm_inc   = norm_inc_q;
  assign bus.guard_bit  = guard_q;
  assign bus.round_bit  = round_q;
  assign bus.sticky_bit = sticky_q;
endmodule

// File: tb/tb_sig_mult_seq.sv
// Bench for sig_mult_seq: directed corners on the 23-bit unit, then a
// concurrent randomized scoreboard sweep over the 23/10/7-bit units.
module tb_sig_mult_seq;
  typedef struct packed {
    logic [23:0] product;
    logic        norm_inc;
    logic        g;
    logic        rb;
    logic        s;
  } res_t;

  localparam int NOPS = 1500;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] a_d [3];
  logic [23:0] b_d [3];
  logic        iv_d[3];
  logic        or_d[3];
  logic        en_d[3];
  logic        ir_o[3];
  logic        ov_o[3];
  logic [23:0] pr_o[3];
  logic        ni_o[3];
  logic        g_o [3];
  logic        r_o [3];
  logic        s_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  res_t q0[$];
  res_t q1[$];
  res_t q2[$];

  for (genvar u = 0; u < 3; u++) begin : g_unit
    localparam int unsigned SW = (u == 0) ? 23 : ((u == 1) ? 10 : 7);
    sig_mult_seq_if #(.sig_width(SW)) bus ();
    sig_mult_seq #(.sig_width(SW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .enable (en_d[u]),
      .bus    (bus)
    );
    assign bus.in_valid  = iv_d[u];
    assign bus.a         = a_d[u][SW:0];
    assign bus.b         = b_d[u][SW:0];
    assign bus.out_ready = or_d[u];
    assign ir_o[u]       = bus.in_ready;
    assign ov_o[u]       = bus.out_valid;
    assign pr_o[u]       = 24'(bus.product);
    assign ni_o[u]       = bus.norm_inc;
    assign g_o[u]        = bus.guard_bit;
    assign r_o[u]        = bus.round_bit;
    assign s_o[u]        = bus.sticky_bit;
  end

  // Exact integer reference: full product then normalize and extract G/R/S.
  function automatic res_t model(input int sw, input logic [23:0] a, input logic [23:0] b);
    res_t        r;
    logic [63:0] p;
    int          w;
    w = sw + 1;
    p = 64'(a) * 64'(b);
    if (((p >> (2 * w - 1)) & 64'd1) != 64'd0) begin
      r.norm_inc = 1'b1;
      r.product  = 24'(p >> w);
      r.g        = p[w-1];
      r.rb       = p[w-2];
      r.s        = (p & ((64'd1 << (w - 2)) - 64'd1)) != 64'd0;
    end else begin
      r.norm_inc = 1'b0;
      r.product  = 24'((p >> (w - 1)) & ((64'd1 << w) - 64'd1));
      r.g        = p[w-2];
      r.rb       = p[w-3];
      r.s        = (p & ((64'd1 << (w - 3)) - 64'd1)) != 64'd0;
    end
    return r;
  endfunction

  function automatic res_t observed(input int u);
    return {pr_o[u], ni_o[u], g_o[u], r_o[u], s_o[u]};
  endfunction

  function automatic void push_exp(input int u, input res_t r);
    case (u)
      0:       q0.push_back(r);
      1:       q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endfunction

  function automatic bit pop_exp(input int u, output res_t r);
    r = '0;
    case (u)
      0: begin if (q0.size() == 0) return 1'b0; r = q0.pop_front(); end
      1: begin if (q1.size() == 0) return 1'b0; r = q1.pop_front(); end
      default: begin if (q2.size() == 0) return 1'b0; r = q2.pop_front(); end
    endcase
    return 1'b1;
  endfunction

  function automatic logic [23:0] pick_op(input int sw);
    logic [23:0] hid;
    logic [23:0] mask;
    int          sel;
    hid  = 24'(32'd1 << sw);
    mask = hid - 24'd1;
    sel  = $urandom_range(0, 9);
    if (sel == 0) return hid | mask;
    if (sel == 1) return hid;
    return hid | (24'($urandom) & mask);
  endfunction

  // Single operation on the 23-bit unit; optional enable gap starting after edge T+stall_at.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input int stall_at,
                        input int stall_len, output int lat, output res_t got);
    @(posedge clk); #1;
    en_d[0] = 1'b1; or_d[0] = 1'b0; iv_d[0] = 1'b1; a_d[0] = a; b_d[0] = b;
    @(posedge clk); #1;
    iv_d[0] = 1'b0; a_d[0] = 24'hFFFFFF; b_d[0] = 24'hAAAAAA;
    lat = 0;
    while (!ov_o[0] && lat < 200) begin
      en_d[0] = !(lat >= stall_at && lat < stall_at + stall_len);
      @(posedge clk); #1;
      lat++;
    end
    en_d[0] = 1'b1;
    got = observed(0);
  endtask

  task automatic release_out();
    or_d[0] = 1'b1;
    @(posedge clk); #1;
    or_d[0] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int u = 0; u < 3; u++) begin
      n_checks++;
      if (ir_o[u] !== 1'b1 || ov_o[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hs[%0d]: in_ready=%b out_valid=%b expected 1/0", u, ir_o[u], ov_o[u]);
      end
      n_checks++;
      if (observed(u) !== res_t'(0)) begin
        n_fail++;
        $display("FAIL reset_out[%0d]: got %h expected 0", u, observed(u));
      end
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_corners();
    logic [23:0] ops [3];
    res_t        exps[3];
    res_t        got;
    res_t        exp;
    int          lat;
    ops[0] = 24'h800000; exps[0] = {24'h800000, 1'b0, 1'b0, 1'b0, 1'b0};
    ops[1] = 24'hFFFFFF; exps[1] = {24'hFFFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    ops[2] = 24'hC00000; exps[2] = {24'h900000, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      push_exp(0, exps[i]);
      run_op(ops[i], ops[i], 1000, 0, lat, got);
      n_checks++;
      if (lat !== 14) begin
        n_fail++;
        $display("FAIL corner%0d_latency: got %0d expected 14", i, lat);
      end
      n_checks++;
      if (!pop_exp(0, exp) || got !== exp) begin
        n_fail++;
        $display("FAIL corner%0d_result: got %h expected %h", i, got, exp);
      end
      release_out();
      n_checks++;
      if (ov_o[0] !== 1'b0 || ir_o[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL corner%0d_release: out_valid=%b in_ready=%b expected 0/1", i, ov_o[0], ir_o[0]);
      end
    end
  endtask

  task automatic test_hold();
    res_t got;
    res_t exp;
    int   lat;
    push_exp(0, model(23, 24'hA5A5A5, 24'hDB6DB7));
    run_op(24'hA5A5A5, 24'hDB6DB7, 1000, 0, lat, got);
    n_checks++;
    if (!pop_exp(0, exp) || got !== exp) begin
      n_fail++;
      $display("FAIL hold_result: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (ov_o[0] !== 1'b1 || ir_o[0] !== 1'b0 || observed(0) !== exp) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: ov=%b ir=%b out=%h expected 1/0/%h", i, ov_o[0], ir_o[0], observed(0), exp);
      end
    end
    release_out();
    n_checks++;
    if (ov_o[0] !== 1'b0 || ir_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b expected 0/1", ov_o[0], ir_o[0]);
    end
  endtask

  task automatic test_reset_abort();
    res_t got;
    res_t exp;
    int   lat;
    @(posedge clk); #1;
    en_d[0] = 1'b1; iv_d[0] = 1'b1; a_d[0] = 24'hFFFFFF; b_d[0] = 24'hFFFFFF;
    @(posedge clk); #1;
    iv_d[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (ov_o[0] !== 1'b0 || ir_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reset: out_valid=%b in_ready=%b expected 0/1", ov_o[0], ir_o[0]);
    end
    @(negedge clk);
    resetn = 1'b1;
    push_exp(0, {24'h800000, 1'b0, 1'b0, 1'b0, 1'b0});
    run_op(24'h800000, 24'h800000, 1000, 0, lat, got);
    n_checks++;
    if (!pop_exp(0, exp) || got !== exp || lat !== 14) begin
      n_fail++;
      $display("FAIL abort_followup: got %h lat %0d expected %h lat 14", got, lat, exp);
    end
    release_out();
  endtask

  task automatic test_enable_stall();
    res_t got;
    res_t exp;
    int   lat;
    push_exp(0, model(23, 24'hB504F3, 24'hF0F0F1));
    run_op(24'hB504F3, 24'hF0F0F1, 4, 3, lat, got);
    n_checks++;
    if (lat !== 17) begin
      n_fail++;
      $display("FAIL stall_latency: got %0d expected 17", lat);
    end
    n_checks++;
    if (!pop_exp(0, exp) || got !== exp) begin
      n_fail++;
      $display("FAIL stall_result: got %h expected %h", got, exp);
    end
    release_out();
  endtask

  task automatic produce(input int u, input int sw, input int n);
    int sent = 0;
    bit acc  = 1'b0;
    while (sent < n) begin
      @(posedge clk); #1;
      en_d[u] = ($urandom_range(0, 7) != 0);
      if (acc) begin
        iv_d[u] = 1'b0; a_d[u] = 24'($urandom); b_d[u] = 24'($urandom); acc = 1'b0;
      end
      if (!iv_d[u] && $urandom_range(0, 3) != 0) begin
        iv_d[u] = 1'b1; a_d[u] = pick_op(sw); b_d[u] = pick_op(sw);
      end
      @(negedge clk);
      if (iv_d[u] && ir_o[u] && en_d[u]) begin
        push_exp(u, model(sw, a_d[u], b_d[u]));
        sent++;
        acc = 1'b1;
      end
    end
    @(posedge clk); #1;
    iv_d[u] = 1'b0; en_d[u] = 1'b1;
  endtask

  task automatic consume(input int u, input int n);
    int   rcv  = 0;
    int   cyc  = 0;
    bit   held = 1'b0;
    res_t exp;
    res_t got;
    while (rcv < n && cyc < 100 * n + 1000) begin
      @(posedge clk); #1;
      or_d[u] = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      cyc++;
      if (held) begin
        n_checks++;
        if (ov_o[u] !== 1'b1) begin
          n_fail++;
          $display("FAIL sweep%0d_gated_handshake: out_valid=%b expected 1", u, ov_o[u]);
        end
        held = 1'b0;
      end
      if (ov_o[u] && or_d[u] && en_d[u]) begin
        got = observed(u);
        n_checks++;
        if (!pop_exp(u, exp)) begin
          n_fail++;
          $display("FAIL sweep%0d_dup: unexpected result %h", u, got);
        end else if (got !== exp) begin
          n_fail++;
          $display("FAIL sweep%0d_result: got %h expected %h", u, got, exp);
        end
        rcv++;
      end else if (ov_o[u] && or_d[u] && !en_d[u]) begin
        held = 1'b1;
      end
    end
    @(posedge clk); #1;
    or_d[u] = 1'b0;
    n_checks++;
    if (rcv != n) begin
      n_fail++;
      $display("FAIL sweep%0d_count: got %0d results expected %0d", u, rcv, n);
    end
  endtask

  task automatic sweep(input int u, input int sw, input int n);
    fork
      produce(u, sw, n);
      consume(u, n);
    join
  endtask

  task automatic test_random_sweep();
    fork
      sweep(0, 23, NOPS);
      sweep(1, 10, NOPS);
      sweep(2, 7, NOPS);
    join
    n_checks++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL sweep_leftover: %0d expected results never produced, expected 0",
               q0.size() + q1.size() + q2.size());
    end
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      a_d[u] = '0; b_d[u] = '0; iv_d[u] = 1'b0; or_d[u] = 1'b0; en_d[u] = 1'b1;
    end
    resetn = 1'b0;
    test_reset();
    test_corners();
    test_hold();
    test_reset_abort();
    test_enable_stall();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
